// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the MEM-stage pipeline signals.
//   EX side : ex_to_mem_valid, ex_to_mem_wire[72:0] in; mem_allowin out
//   WB side : mem_to_wb_valid, mem_to_wb_wire[69:0] out; wb_allowin in
//   SRAM    : data_sram_data_ok, data_sram_rdata[31:0] in
//   ID side : mem_rf_zip[38:0] out (forwarding / load-wait bundle)
// Modport slave is the MEM stage itself; master is the surrounding pipeline.
interface mem_stage_if;
  logic        mem_allowin;
  logic        ex_to_mem_valid;
  logic [72:0] ex_to_mem_wire;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_wire;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] mem_rf_zip;

  modport slave (
    output mem_allowin, mem_to_wb_valid, mem_to_wb_wire, mem_rf_zip,
    input  ex_to_mem_valid, ex_to_mem_wire, wb_allowin,
           data_sram_data_ok, data_sram_rdata
  );

  modport master (
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_wire, mem_rf_zip,
    output ex_to_mem_valid, ex_to_mem_wire, wb_allowin,
           data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Latches the EX payload, waits for the data SRAM response on loads,
// aligns and extends the load data, and hands {rf_we, rf_waddr, rf_wdata, pc}
// to WB over the valid/allowin handshake. A load response that arrives while
// WB is stalled is parked in a one-entry buffer.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   bus    - mem_stage_if.slave (EX, WB, data SRAM and ID forwarding signals)
module mem_stage (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave bus
);

  logic        mem_valid_reg;
  logic [72:0] payload_reg;
  logic [31:0] rdata_buf_reg;
  logic        rdata_buf_valid_reg;

  // payload fields
  logic [2:0]  ld_type;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign ld_type    = payload_reg[72:70];
  assign rf_we      = payload_reg[69];
  assign rf_waddr   = payload_reg[68:64];
  assign alu_result = payload_reg[63:32];
  assign pc         = payload_reg[31:0];

  logic is_load;
  logic mem_ready_go;
  logic handoff;
  logic buf_set;

  // Encodings 6 and 7 fall outside the load range and act as non-loads.
  assign is_load      = (ld_type >= 3'd1) && (ld_type <= 3'd5);
  assign mem_ready_go = ~is_load | bus.data_sram_data_ok | rdata_buf_valid_reg;
  assign bus.mem_allowin     = ~mem_valid_reg | (mem_ready_go & bus.wb_allowin);
  assign bus.mem_to_wb_valid = mem_valid_reg & mem_ready_go;
  assign handoff = bus.mem_to_wb_valid & bus.wb_allowin;
  // Only capture a live response that WB cannot take this cycle.
  assign buf_set = mem_valid_reg & is_load & bus.data_sram_data_ok &
                   ~rdata_buf_valid_reg & ~bus.wb_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_reg <= 1'b0;
      payload_reg   <= '0;
    end else if (bus.mem_allowin) begin
      mem_valid_reg <= bus.ex_to_mem_valid;
      if (bus.ex_to_mem_valid) begin
        payload_reg <= bus.ex_to_mem_wire;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf_valid_reg <= 1'b0;
      rdata_buf_reg       <= '0;
    end else if (handoff) begin
      rdata_buf_valid_reg <= 1'b0;
    end else if (buf_set) begin
      rdata_buf_valid_reg <= 1'b1;
      rdata_buf_reg       <= bus.data_sram_rdata;
    end
  end

  // Load data alignment
  logic [31:0] raw;
  logic [1:0]  off;
  logic [7:0]  raw_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] aligned;
  logic [31:0] rf_wdata;

  // Once buffered, the SRAM bus may carry unrelated data, so prefer the buffer.
  assign raw = rdata_buf_valid_reg ? rdata_buf_reg : bus.data_sram_rdata;
  assign off = alu_result[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign raw_byte[gi] = raw[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = raw_byte[off];
  assign sel_half = off[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    aligned = raw;
    case (ld_type)
      3'd1:    aligned = {{24{sel_byte[7]}}, sel_byte};
      3'd2:    aligned = {{16{sel_half[15]}}, sel_half};
      3'd4:    aligned = {24'd0, sel_byte};
      3'd5:    aligned = {16'd0, sel_half};
      default: aligned = raw;
    endcase
  end

  assign rf_wdata = is_load ? aligned : alu_result;

  logic mem_ld_wait;
  assign mem_ld_wait = mem_valid_reg & is_load & ~mem_ready_go;

  assign bus.mem_to_wb_wire = {rf_we, rf_waddr, rf_wdata, pc};
  assign bus.mem_rf_zip     = {mem_ld_wait, rf_we & mem_valid_reg, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_stage_if bus ();

  mem_stage u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from EX for a single accepting cycle.
  task automatic send(input logic [2:0] ld, input logic [4:0] wa,
                      input logic [31:0] alu, input logic [31:0] pc);
    bus.ex_to_mem_valid = 1'b1;
    bus.ex_to_mem_wire  = {ld, 1'b1, wa, alu, pc};
    tick();
    bus.ex_to_mem_valid = 1'b0;
    #1;
  endtask

  // Load with its response in the cycle after acceptance.
  task automatic load_chk(input string tag, input logic [2:0] ld, input logic [1:0] off,
                          input logic [31:0] rdata, input logic [31:0] exp);
    send(ld, 5'd9, {30'h0400_0000, off}, 32'h1C00_0100);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = rdata;
    #1;
    check({tag, "_valid"}, {69'd0, bus.mem_to_wb_valid}, 70'd1);
    check({tag, "_wdata"}, {38'd0, bus.mem_to_wb_wire[63:32]}, {38'd0, exp});
    $display("load %s ld_type=%0d off=%0d rdata=%h wdata=%h", tag, ld, off, rdata,
             bus.mem_to_wb_wire[63:32]);
    tick();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
  endtask

  initial begin
    bus.ex_to_mem_valid   = 1'b0;
    bus.ex_to_mem_wire    = '0;
    bus.wb_allowin        = 1'b1;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_valid",   {69'd0, bus.mem_to_wb_valid}, 70'd0);
    check("rst_allowin", {69'd0, bus.mem_allowin}, 70'd1);
    check("rst_wire",    bus.mem_to_wb_wire, 70'd0);
    check("rst_zip",     {31'd0, bus.mem_rf_zip}, 70'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Non-load pass-through
    send(3'd0, 5'd5, 32'h1234_5678, 32'h1C00_0010);
    check("nl_valid", {69'd0, bus.mem_to_wb_valid}, 70'd1);
    check("nl_wire",  bus.mem_to_wb_wire, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0010});
    check("nl_zip",   {31'd0, bus.mem_rf_zip}, {31'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678});
    $display("nonload waddr=5 wdata=%h", bus.mem_to_wb_wire[63:32]);
    tick();
    check("nl_left", {69'd0, bus.mem_to_wb_valid}, 70'd0);

    // Type 6 behaves as a non-load
    send(3'd6, 5'd4, 32'h55AA_00FF, 32'h1C00_0020);
    check("t6_valid", {69'd0, bus.mem_to_wb_valid}, 70'd1);
    check("t6_wdata", {38'd0, bus.mem_to_wb_wire[63:32]}, {38'd0, 32'h55AA_00FF});
    tick();

    // Byte loads
    load_chk("ldb_off3",  3'd1, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
    load_chk("ldbu_off3", 3'd4, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
    load_chk("ldb_off1",  3'd1, 2'd1, 32'h80FF_7F01, 32'h0000_007F);
    load_chk("ldb_off2",  3'd1, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
    load_chk("ldbu_off0", 3'd4, 2'd0, 32'h80FF_7F01, 32'h0000_0001);
    // Halfword loads
    load_chk("ldh_off2",  3'd2, 2'd2, 32'h8001_7FFE, 32'hFFFF_8001);
    load_chk("ldhu_off2", 3'd5, 2'd2, 32'h8001_7FFE, 32'h0000_8001);
    load_chk("ldh_off0",  3'd2, 2'd0, 32'h8001_7FFE, 32'h0000_7FFE);
    load_chk("ldh_off1",  3'd2, 2'd1, 32'h8001_7FFE, 32'h0000_7FFE);
    load_chk("ldhu_off3", 3'd5, 2'd3, 32'h8001_7FFE, 32'h0000_8001);
    load_chk("ldw",       3'd3, 2'd0, 32'h8001_7FFE, 32'h8001_7FFE);

    // Delayed response
    send(3'd3, 5'd10, 32'h0000_0100, 32'h1C00_0200);
    for (int i = 0; i < 3; i++) begin
      check("dly_wait",    {69'd0, bus.mem_rf_zip[38]}, 70'd1);
      check("dly_allowin", {69'd0, bus.mem_allowin}, 70'd0);
      check("dly_valid",   {69'd0, bus.mem_to_wb_valid}, 70'd0);
      tick();
    end
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("dly_ok_valid", {69'd0, bus.mem_to_wb_valid}, 70'd1);
    check("dly_ok_wdata", {38'd0, bus.mem_to_wb_wire[63:32]}, {38'd0, 32'hDEAD_BEEF});
    check("dly_ok_wait",  {69'd0, bus.mem_rf_zip[38]}, 70'd0);
    $display("delayed load wdata=%h", bus.mem_to_wb_wire[63:32]);
    tick();
    bus.data_sram_data_ok = 1'b0;

    // Response during WB stall, then simultaneous leave and enter
    send(3'd3, 5'd11, 32'h0000_0200, 32'h1C00_0300);
    bus.wb_allowin        = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hCAFE_0001;
    #1;
    check("stl_valid0",   {69'd0, bus.mem_to_wb_valid}, 70'd1);
    check("stl_wdata0",   {38'd0, bus.mem_to_wb_wire[63:32]}, {38'd0, 32'hCAFE_0001});
    check("stl_allowin0", {69'd0, bus.mem_allowin}, 70'd0);
    tick();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stl_bufv",  {69'd0, u_dut.rdata_buf_valid_reg}, 70'd1);
      check("stl_valid", {69'd0, bus.mem_to_wb_valid}, 70'd1);
      check("stl_wdata", {38'd0, bus.mem_to_wb_wire[63:32]}, {38'd0, 32'hCAFE_0001});
      tick();
    end
    bus.wb_allowin      = 1'b1;
    bus.ex_to_mem_valid = 1'b1;
    bus.ex_to_mem_wire  = {3'd0, 1'b1, 5'd7, 32'hAAAA_5555, 32'h1C00_0400};
    #1;
    check("rel_valid",   {69'd0, bus.mem_to_wb_valid}, 70'd1);
    check("rel_wdata",   {38'd0, bus.mem_to_wb_wire[63:32]}, {38'd0, 32'hCAFE_0001});
    check("rel_allowin", {69'd0, bus.mem_allowin}, 70'd1);
    $display("stalled load handed off wdata=%h", bus.mem_to_wb_wire[63:32]);
    tick();
    bus.ex_to_mem_valid = 1'b0;
    #1;
    check("swap_bufv",  {69'd0, u_dut.rdata_buf_valid_reg}, 70'd0);
    check("swap_valid", {69'd0, bus.mem_to_wb_valid}, 70'd1);
    check("swap_wire",  bus.mem_to_wb_wire, {1'b1, 5'd7, 32'hAAAA_5555, 32'h1C00_0400});
    tick();
    check("swap_left", {69'd0, bus.mem_to_wb_valid}, 70'd0);

    // data_ok with MEM empty is ignored
    bus.wb_allowin        = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h1111_1111;
    #1;
    check("idle_valid", {69'd0, bus.mem_to_wb_valid}, 70'd0);
    tick();
    bus.data_sram_data_ok = 1'b0;
    check("idle_bufv", {69'd0, u_dut.rdata_buf_valid_reg}, 70'd0);
    bus.wb_allowin = 1'b1;
    tick();

    // Reset mid-load with a buffered response
    send(3'd3, 5'd12, 32'h0000_0300, 32'h1C00_0500);
    bus.wb_allowin        = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0000_0012;
    tick();
    bus.data_sram_data_ok = 1'b0;
    check("mr_pre_bufv", {69'd0, u_dut.rdata_buf_valid_reg}, 70'd1);
    resetn = 1'b0;
    #1;
    check("mr_valid",   {69'd0, bus.mem_to_wb_valid}, 70'd0);
    check("mr_allowin", {69'd0, bus.mem_allowin}, 70'd1);
    check("mr_zip",     {31'd0, bus.mem_rf_zip}, 70'd0);
    check("mr_bufv",    {69'd0, u_dut.rdata_buf_valid_reg}, 70'd0);
    check("mr_wire",    bus.mem_to_wb_wire, 70'd0);
    tick();
    resetn         = 1'b1;
    bus.wb_allowin = 1'b1;
    tick();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0000_0034;
    #1;
    check("post_valid", {69'd0, bus.mem_to_wb_valid}, 70'd0);
    check("post_zip",   {31'd0, bus.mem_rf_zip}, 70'd0);
    tick();
    bus.data_sram_data_ok = 1'b0;
    check("post_bufv", {69'd0, u_dut.rdata_buf_valid_reg}, 70'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting between the EX stage and the WB stage. It latches EX results and, for loads, waits for the data SRAM response. It then aligns and sign/zero-extends the returned data and forwards `{rf_we, rf_waddr, rf_wdata, pc}` to WB using the valid/allowin handshake. It also drives the MEM-stage forwarding/stall bundle back to ID, and buffers a load response that arrives while WB is stalled.

## Interface
Parameters:
- none (all widths fixed by the pipeline bus format)

Ports:
- `clk`  in  1  sole clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `mem_allowin`  out  1  MEM can accept a new instruction this cycle
- `ex_to_mem_valid`  in  1  EX holds a valid instruction for MEM
- `ex_to_mem_wire`  in  73  `{ld_type[2:0], rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}`
- `wb_allowin`  in  1  WB can accept this cycle
- `mem_to_wb_valid`  out  1  MEM output valid toward WB
- `mem_to_wb_wire`  out  70  `{rf_we, rf_waddr[4:0], rf_wdata[31:0], pc[31:0]}`
- `data_sram_data_ok`  in  1  one-cycle pulse: read data for the oldest outstanding load is on `data_sram_rdata`
- `data_sram_rdata`  in  32  load response data
- `mem_rf_zip`  out  39  `{mem_ld_wait, rf_we & mem_valid, rf_waddr[4:0], rf_wdata[31:0]}` to ID

## Operation
Load type encoding (`ld_type`):
- 0 = not a load
- 1 = ld.b, 2 = ld.h, 3 = ld.w, 4 = ld.bu, 5 = ld.hu
- 6 and 7 behave as 0

State and capture:
- Registers: `mem_valid`, the 73-bit payload register, `rdata_buf[31:0]`, `rdata_buf_valid`.
- `is_load = (ld_type in 1..5)`.
- Accept: when `mem_allowin`, `mem_valid <= ex_to_mem_valid`.
- The payload register loads only when `ex_to_mem_valid & mem_allowin`; otherwise it holds.

Handshake:
- `mem_ready_go = ~is_load | data_sram_data_ok | rdata_buf_valid`
- `mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin)`
- `mem_to_wb_valid = mem_valid & mem_ready_go`

Load data source:
- `raw = rdata_buf_valid ? rdata_buf : data_sram_rdata`.

Response buffer:
- Sets when `mem_valid & is_load & data_sram_data_ok & ~rdata_buf_valid & ~wb_allowin`; it captures `data_sram_rdata` into `rdata_buf`.
- Clears when the instruction leaves MEM (`mem_to_wb_valid & wb_allowin`).
- `data_sram_data_ok` while `~mem_valid`, or while the MEM instruction is not a load, is ignored.

Alignment, with `off = alu_result[1:0]`:
- ld.b / ld.bu: byte `raw[8*off+7 : 8*off]`, sign-extended (ld.b) or zero-extended (ld.bu).
- ld.h / ld.hu: `off[1]` selects `raw[31:16]` or `raw[15:0]`; `off[0]` is ignored; sign-extended or zero-extended respectively.
- ld.w: `raw` unchanged.
- Alignment is not checked here.

Write-back value:
- `rf_wdata = is_load ? aligned : alu_result`.
- `rf_we` and `rf_waddr` pass through unchanged; `pc` passes through.

Forwarding bundle:
- `mem_ld_wait = mem_valid & is_load & ~mem_ready_go`. ID must stall on a register match while this is 1.
- When `mem_ld_wait = 1`, the `rf_wdata` field of `mem_rf_zip` is don't-care.

## Timing
- Asynchronous reset:
  - `mem_valid`, `rdata_buf_valid`, and the payload register go to 0 immediately.
  - Hence `mem_to_wb_valid = 0`, `mem_allowin = 1`, `mem_to_wb_wire = 0`, `mem_rf_zip = 0`.
  - Reset removal is synchronized externally.
- Latency:
  - Non-load: one cycle from EX acceptance to `mem_to_wb_valid`.
  - Load: `mem_to_wb_valid` is combinational from `data_sram_data_ok` in the same cycle, or from the buffer on following cycles.
- Throughput: one instruction per cycle when every load's `data_ok` arrives in the cycle after acceptance and `wb_allowin = 1`.
- WB stall: output and payload hold stable while `mem_to_wb_valid & ~wb_allowin`. A `data_ok` pulse during the stall is captured so that it is not lost.
- Simultaneous leave and enter: when MEM hands off to WB and EX delivers in the same cycle, the new payload replaces the old on that edge and `rdata_buf_valid` clears.
- Reset mid-load: the outstanding instruction is dropped. A `data_ok` after reset arrives with `mem_valid = 0` and is ignored.

## Test plan
- Reset mid-operation:
  - Stimulus: assert `resetn=0` with `mem_valid=1` and a buffered load.
  - Required: in the same cycle `mem_to_wb_valid=0`, `mem_allowin=1`, `mem_rf_zip=0`, `rdata_buf_valid=0`.
- Non-load pass-through:
  - Stimulus: `ld_type=0`, `alu_result=0x1234_5678`, `rf_waddr=5`, `pc=0x1C00_0010`.
  - Required: next cycle `mem_to_wb_wire={1,5,0x12345678,0x1C000010}` and `mem_to_wb_valid=1`.
- Byte loads:
  - Stimulus: `rdata=0x80FF_7F01`; ld.b with off=3, ld.bu with off=3, ld.b with off=1.
  - Required: `rf_wdata` = `0xFFFF_FF80`, `0x0000_0080`, `0x0000_007F` respectively.
- Halfword loads:
  - Stimulus: `rdata=0x8001_7FFE`; ld.h with off=2, ld.hu with off=2, ld.h with off=0 (and off=1).
  - Required: `rf_wdata` = `0xFFFF_8001`, `0x0000_8001`, `0x0000_7FFE` (same value for off=0 and off=1).
- Delayed response:
  - Stimulus: ld.w accepted; `data_ok` arrives 3 cycles later with `0xDEAD_BEEF`.
  - Required: `mem_ld_wait=1` and `mem_allowin=0` for 3 cycles; in the `data_ok` cycle `mem_to_wb_valid=1` and `rf_wdata=0xDEADBEEF`.
- Response during WB stall:
  - Stimulus: `wb_allowin=0` when `data_ok` pulses with `0xCAFE_0001`; release `wb_allowin` 2 cycles later.
  - Required: `mem_to_wb_valid` stays 1 and `rf_wdata` stays `0xCAFE0001` throughout; the buffer clears on handoff.
